// File: rtl/hazard_control_unit_pkg.sv
// Purpose: shared codes for the ID-stage hazard controller (forward selects, FSM states, PC reg).
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
package hazard_control_unit_pkg;

  // Operand source selects driven onto fwd_a / fwd_b.
  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b01;
  localparam logic [1:0] FWD_MEMWB   = 2'b10;
  // Reserved: the datapath has a WB-latch input, but this controller never selects it.
  localparam logic [1:0] FWD_WBLATCH = 2'b11;

  // R15 is the PC: it is never written through the normal RF path, so it can
  // neither cause a load-use stall nor be a forwarding source.
  localparam logic [3:0] REG_PC = 4'd15;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } hcu_state_e;

  // True when a stage that writes register rd produces the value src needs.
  function automatic logic reg_match(input logic [3:0] rd,
                                     input logic       reg_write,
                                     input logic [3:0] src);
    return reg_write && (rd == src) && (src != REG_PC);
  endfunction

endpackage

// File: rtl/hazard_control_unit_fwd_select.sv
// Purpose: per-operand forwarding select for the EX stage (EX/MEM beats MEM/WB beats RF).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the select is a pure function of the current pipeline register fields.
//
// Ports:
//   src, src_use                 source register of the ID operand and whether it is read
//   mem_rd, mem_reg_write        destination / RegWrite of the EX/MEM instruction
//   wb_rd, wb_reg_write          destination / RegWrite of the MEM/WB instruction
//   sel                          2-bit operand source select (FWD_* codes)
module fwd_select
  import hazard_control_unit_pkg::*;
(
  input  logic [3:0] src,
  input  logic       src_use,
  input  logic [3:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [3:0] wb_rd,
  input  logic       wb_reg_write,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (src_use) begin
      // The younger producer (EX/MEM) holds the newer value, so it wins.
      if (reg_match(mem_rd, mem_reg_write, src)) begin
        sel = FWD_EXMEM;
      end else if (reg_match(wb_rd, wb_reg_write, src)) begin
        sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Purpose: ID-stage hazard controller: load-use stall FSM, taken-branch flush, EX forwarding.
// Latency: control outputs are Mealy (same cycle as detection); counters update on the next edge.
// Backpressure: this block is the stall source; it never waits on anything downstream.
//
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   id_src1/2, id_use_src1/2          operands of the IF/ID instruction and their read enables
//   ex_rd, ex_reg_write, ex_load      ID/EX destination, RegWrite, load flag
//   mem_rd, mem_reg_write             EX/MEM destination and RegWrite
//   wb_rd, wb_reg_write               MEM/WB destination and RegWrite
//   branch_taken                      taken B/BL resolved in EX
//   pc_enable, if_id_enable           PC and IF/ID register enables
//   if_id_flush                       IF/ID loads a NOP on the next edge
//   cu_mux_select                     1 = inject an all-zero control bubble into ID/EX
//   fwd_a, fwd_b                      EX operand source selects
//   stall_count, flush_count          saturating bubble / flush event counters
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  // Bubbles inserted per load-use hazard; valid range 1..7.
  parameter int unsigned LOAD_USE_STALL = 1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic [3:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_load,
  input  logic [3:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [3:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic             branch_taken,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             cu_mux_select,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // The detecting RUN cycle is the first bubble, so STALL supplies the rest:
  // entering with cnt = N-2 and leaving after the cnt==0 cycle gives N-1 more.
  localparam int unsigned RELOAD_INT   = (LOAD_USE_STALL >= 2) ? (LOAD_USE_STALL - 2) : 0;
  localparam logic [2:0]  STALL_RELOAD = RELOAD_INT[2:0];

  hcu_state_e       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_inc, flush_inc;
  logic             hz;
  logic [1:0]       sel_a, sel_b;

  // Load-use: the ID instruction needs a register the load in EX has not fetched yet.
  assign hz = ex_load &&
              ((id_use_src1 && reg_match(ex_rd, ex_reg_write, id_src1)) ||
               (id_use_src2 && reg_match(ex_rd, ex_reg_write, id_src2)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    if_id_flush   = 1'b0;
    cu_mux_select = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;

    if (reset) begin
      // Hold a bubble in ID/EX while in reset, but let fetch run freely.
      cu_mux_select = 1'b1;
    end else if (branch_taken) begin
      // Wrong-path instructions in IF/ID and ID are squashed; any pending
      // stall belonged to one of them, so it is dropped.
      if_id_flush   = 1'b1;
      cu_mux_select = 1'b1;
      state_d       = ST_RUN;
      cnt_d         = 3'd0;
      flush_inc     = 1'b1;
    end else if (state_q == ST_STALL) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      cu_mux_select = 1'b1;
      stall_inc     = 1'b1;
      if (cnt_q == 3'd0) begin
        state_d = ST_RUN;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
    end else if (hz) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      cu_mux_select = 1'b1;
      stall_inc     = 1'b1;
      if (LOAD_USE_STALL > 1) begin
        state_d = ST_STALL;
        cnt_d   = STALL_RELOAD;
      end
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (flush_inc && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;

  fwd_select u_fwd_a (
    .src           (id_src1),
    .src_use       (id_use_src1),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (sel_a)
  );

  fwd_select u_fwd_b (
    .src           (id_src2),
    .src_use       (id_use_src2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (sel_b)
  );

  // Pipeline register contents are meaningless during reset; select the RF.
  assign fwd_a = reset ? FWD_RF : sel_a;
  assign fwd_b = reset ? FWD_RF : sel_b;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Purpose: directed bench for hazard_control_unit with a queue of expected results.
// Latency: checks combinational outputs 1 ns after each input change; counters one edge later.
// Backpressure: n/a.
module tb_hazard_control_unit;

  logic       clk;
  logic       reset;
  logic [3:0] id_src1, id_src2, ex_rd, mem_rd, wb_rd;
  logic       id_use_src1, id_use_src2, ex_reg_write, ex_load;
  logic       mem_reg_write, wb_reg_write, branch_taken;

  // Instance with a single-bubble stall and 2-bit counters (saturation visible quickly).
  logic       pc1, ifid1, fl1, cu1;
  logic [1:0] fa1, fb1, sc1, fc1;
  // Instance with a three-bubble stall and full-width counters.
  logic        pc3, ifid3, fl3, cu3;
  logic [1:0]  fa3, fb3;
  logic [15:0] sc3, fc3;

  hazard_control_unit #(.LOAD_USE_STALL(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .reset(reset), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_load(ex_load), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .branch_taken(branch_taken), .pc_enable(pc1), .if_id_enable(ifid1),
    .if_id_flush(fl1), .cu_mux_select(cu1), .fwd_a(fa1), .fwd_b(fb1),
    .stall_count(sc1), .flush_count(fc1)
  );

  hazard_control_unit #(.LOAD_USE_STALL(3), .CNT_W(16)) u_dut3 (
    .clk(clk), .reset(reset), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_load(ex_load), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .branch_taken(branch_taken), .pc_enable(pc3), .if_id_enable(ifid3),
    .if_id_flush(fl3), .cu_mux_select(cu3), .fwd_a(fa3), .fwd_b(fb3),
    .stall_count(sc3), .flush_count(fc3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Kinds of observation: control nibble {pc,ifid,flush,cu} of each instance,
  // {fwd_a,fwd_b} of the 3-bubble instance, and {stall,flush} counters of each.
  localparam logic [2:0] K_CTL1 = 3'd0;
  localparam logic [2:0] K_CTL3 = 3'd1;
  localparam logic [2:0] K_FWD  = 3'd2;
  localparam logic [2:0] K_CNT1 = 3'd3;
  localparam logic [2:0] K_CNT3 = 3'd4;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] val;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

  function automatic logic [31:0] observe(input logic [2:0] kind);
    case (kind)
      K_CTL1:  return {28'd0, pc1, ifid1, fl1, cu1};
      K_CTL3:  return {28'd0, pc3, ifid3, fl3, cu3};
      K_FWD:   return {28'd0, fa3, fb3};
      K_CNT1:  return {28'd0, sc1, fc1};
      default: return {sc3, fc3};
    endcase
  endfunction

  task automatic expect_val(input string tag, input logic [2:0] kind, input logic [31:0] v);
    exp_t e;
    e.kind = kind;
    e.val  = v;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_now();
    exp_t        e;
    string       t;
    logic [31:0] o;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = observe(e.kind);
      checks++;
      assert (o === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", t, o, e.val);
      end
    end
  endtask

  task automatic clear_inputs();
    id_src1 = 4'd0; id_src2 = 4'd0; id_use_src1 = 1'b0; id_use_src2 = 1'b0;
    ex_rd = 4'd0; ex_reg_write = 1'b0; ex_load = 1'b0;
    mem_rd = 4'd0; mem_reg_write = 1'b0; wb_rd = 4'd0; wb_reg_write = 1'b0;
    branch_taken = 1'b0;
  endtask

  // Load of r2 in EX, ID instruction reads r2 as Rn.
  task automatic set_load_use();
    ex_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 4'd2;
    id_src1 = 4'd2; id_use_src1 = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    // Forwarding candidates present during reset must still give RF selects.
    id_src1 = 4'd4; id_use_src1 = 1'b1; mem_rd = 4'd4; mem_reg_write = 1'b1;
    expect_val("reset_ctl", K_CTL1, 32'h0000_000D);
    expect_val("reset_fwd", K_FWD,  32'h0);
    expect_val("reset_cnt", K_CNT3, 32'h0);
    check_now();
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();

    // Single-bubble load-use.
    @(negedge clk); set_load_use();
    expect_val("lu1_bubble", K_CTL1, 32'h1);
    expect_val("lu1_cnt0",   K_CNT1, 32'h0);
    check_now();
    @(negedge clk); ex_load = 1'b0; ex_reg_write = 1'b0;   // bubble now in EX
    expect_val("lu1_resume", K_CTL1, 32'hC);
    expect_val("lu1_cnt",    K_CNT1, 32'h4);
    check_now();
    @(negedge clk);
    expect_val("lu1_cnt_hold", K_CNT1, 32'h4);
    check_now();

    // Three-bubble load-use.
    do_reset();
    @(negedge clk); set_load_use();
    expect_val("lu3_b1", K_CTL3, 32'h1);
    check_now();
    @(negedge clk); ex_load = 1'b0; ex_reg_write = 1'b0;
    expect_val("lu3_b2", K_CTL3, 32'h1);
    check_now();
    @(negedge clk);
    expect_val("lu3_b3",  K_CTL3, 32'h1);
    expect_val("lu3_cnt2", K_CNT3, {16'd2, 16'd0});
    check_now();
    @(negedge clk);
    expect_val("lu3_run", K_CTL3, 32'hC);
    expect_val("lu3_cnt3", K_CNT3, {16'd3, 16'd0});
    check_now();

    // Branch taken in the second STALL-state cycle (two bubbles already issued).
    do_reset();
    @(negedge clk); set_load_use();
    expect_val("br_b1", K_CTL3, 32'h1);
    check_now();
    @(negedge clk); ex_load = 1'b0; ex_reg_write = 1'b0;
    expect_val("br_b2", K_CTL3, 32'h1);
    check_now();
    @(negedge clk); branch_taken = 1'b1;
    expect_val("br_flush", K_CTL3, 32'hF);
    expect_val("br_cnt_before", K_CNT3, {16'd2, 16'd0});
    check_now();
    @(negedge clk); branch_taken = 1'b0;
    expect_val("br_after", K_CTL3, 32'hC);
    expect_val("br_cnt", K_CNT3, {16'd2, 16'd1});
    check_now();
    @(negedge clk);
    expect_val("br_no_residual", K_CTL3, 32'hC);
    check_now();

    // Forwarding priority.
    @(negedge clk); clear_inputs();
    mem_rd = 4'd5; mem_reg_write = 1'b1; wb_rd = 4'd5; wb_reg_write = 1'b1;
    id_src2 = 4'd5; id_use_src2 = 1'b1;
    expect_val("fwd_b_exmem", K_FWD, 32'h1);
    check_now();
    @(negedge clk); mem_reg_write = 1'b0;
    expect_val("fwd_b_memwb", K_FWD, 32'h2);
    check_now();
    @(negedge clk); wb_reg_write = 1'b0;
    expect_val("fwd_b_rf", K_FWD, 32'h0);
    check_now();
    @(negedge clk); mem_reg_write = 1'b1; wb_reg_write = 1'b1; id_use_src2 = 1'b0;
    expect_val("fwd_b_nouse", K_FWD, 32'h0);
    check_now();
    @(negedge clk); id_src1 = 4'd7; id_use_src1 = 1'b1; mem_rd = 4'd7; wb_rd = 4'd7;
    expect_val("fwd_a_exmem", K_FWD, 32'h4);
    check_now();
    @(negedge clk); mem_rd = 4'd9;
    expect_val("fwd_a_memwb", K_FWD, 32'h8);
    check_now();

    // R15 and non-hazard cases.
    @(negedge clk); clear_inputs();
    ex_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 4'd15; id_src1 = 4'd15; id_use_src1 = 1'b1;
    mem_rd = 4'd15; mem_reg_write = 1'b1; wb_rd = 4'd15; wb_reg_write = 1'b1;
    expect_val("r15_nostall", K_CTL3, 32'hC);
    expect_val("r15_nofwd",   K_FWD,  32'h0);
    check_now();
    @(negedge clk); ex_rd = 4'd3; id_src1 = 4'd0; id_src2 = 4'd3; id_use_src2 = 1'b0;
    expect_val("nouse_nostall", K_CTL1, 32'hC);
    check_now();
    @(negedge clk); id_use_src2 = 1'b1; ex_load = 1'b0;
    expect_val("noload_nostall", K_CTL3, 32'hC);
    check_now();
    @(negedge clk); ex_load = 1'b1; ex_reg_write = 1'b0;
    expect_val("nowrite_nostall", K_CTL1, 32'hC);
    check_now();

    // Reset asserted mid-stall.
    do_reset();
    @(negedge clk); set_load_use();
    expect_val("rst_b1", K_CTL3, 32'h1);
    check_now();
    @(negedge clk); ex_load = 1'b0; ex_reg_write = 1'b0;
    expect_val("rst_b2", K_CTL3, 32'h1);
    check_now();
    #2;
    reset = 1'b1;
    mem_rd = 4'd2; mem_reg_write = 1'b1;
    expect_val("rst_ctl", K_CTL3, 32'hD);
    expect_val("rst_cnt", K_CNT3, 32'h0);
    expect_val("rst_fwd", K_FWD,  32'h0);
    check_now();
    @(negedge clk); reset = 1'b0; clear_inputs();
    expect_val("rel_run", K_CTL3, 32'hC);
    check_now();
    @(negedge clk);
    expect_val("rel_run2", K_CTL3, 32'hC);
    expect_val("rel_cnt",  K_CNT3, 32'h0);
    check_now();

    // Counter saturation on the 2-bit instance.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); set_load_use();
      expect_val($sformatf("sat_bubble%0d", i), K_CTL1, 32'h1);
      check_now();
      @(negedge clk); clear_inputs();
      expect_val($sformatf("sat_run%0d", i), K_CTL1, 32'hC);
      check_now();
    end
    @(negedge clk);
    expect_val("sat_stall", K_CNT1, 32'hC);
    check_now();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); branch_taken = 1'b1;
      expect_val($sformatf("sat_flush%0d", i), K_CTL1, 32'hF);
      check_now();
    end
    @(negedge clk); branch_taken = 1'b0;
    expect_val("sat_both", K_CNT1, 32'hF);
    check_now();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
